// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine. A block gets the initial AddRoundKey when it is
// accepted, then one full round per clock for NR rounds, and is held until taken.
module aes_round_engine #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128 * (NR + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] expanded_key,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  block_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  block_out,
  output logic          busy,
  output logic [3:0]    round_idx
);
  localparam int unsigned BW   = 128;
  localparam logic [3:0]  LAST = 4'(NR);

  // Only AES-128/192/256 round counts are meaningful.
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if (KW != 128 * (NR + 1)) begin : g_bad_kw
    $error("aes_round_engine: KW must equal 128*(NR+1)");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state_q, state_d;
  logic [BW-1:0]  data_q, data_d, out_d;
  logic [3:0]     round_d;
  logic [BW-1:0]  rk [NR+1];
  logic [BW-1:0]  rk_cur, sr_vec, mc_vec;
  logic [7:0]     st_b [16];
  logic [7:0]     sb_b [16];
  logic [7:0]     sr_b [16];
  logic [7:0]     mc_b [16];

  for (genvar r = 0; r < NR + 1; r++) begin : g_rk
    assign rk[r] = expanded_key[KW-1-128*r -: 128];
  end
  assign rk_cur = rk[round_idx];

  // Byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r.
  for (genvar i = 0; i < 16; i++) begin : g_bytes
    localparam int unsigned ROW = i % 4;
    localparam int unsigned COL = i / 4;
    assign st_b[i] = data_q[BW-1-8*i -: 8];
    assign sb_b[i] = SBOX[st_b[i]];
    assign sr_b[i] = sb_b[ROW + 4*((COL + ROW) % 4)];
    assign sr_vec[BW-1-8*i -: 8] = sr_b[i];
    assign mc_vec[BW-1-8*i -: 8] = mc_b[i];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_b[4*c];
    assign a1 = sr_b[4*c+1];
    assign a2 = sr_b[4*c+2];
    assign a3 = sr_b[4*c+3];
    assign mc_b[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Next state; block_out is loaded only with the finished ciphertext.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    round_d = round_idx;
    out_d   = block_out;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = block_in ^ rk[0];
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (round_idx == LAST) begin
          data_d  = sr_vec ^ rk_cur;
          out_d   = sr_vec ^ rk_cur;
          state_d = DONE;
        end else begin
          data_d  = mc_vec ^ rk_cur;
          round_d = round_idx + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
          out_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      block_out <= '0;
      round_idx <= 4'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      block_out <= out_d;
      round_idx <= round_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 / SP800-38A vectors for NR=10/12/14,
// latency, back-pressure, back-to-back throughput and asynchronous reset.
module tb_aes_round_engine;
  localparam int unsigned KW10 = 1408;
  localparam int unsigned KW12 = 1664;
  localparam int unsigned KW14 = 1920;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [KW10-1:0] key10 = '0;
  logic [KW12-1:0] key12 = '0;
  logic [KW14-1:0] key14 = '0;
  logic [127:0] block_in = '0;
  logic out_ready = 1'b0;
  logic in_valid10 = 1'b0, in_valid12 = 1'b0, in_valid14 = 1'b0;
  logic in_ready10, in_ready12, in_ready14;
  logic out_valid10, out_valid12, out_valid14;
  logic busy10, busy12, busy14;
  logic [127:0] block_out10, block_out12, block_out14;
  logic [3:0] round_idx10, round_idx12, round_idx14;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] sbox_t [256];
  logic [1919:0] sched;

  aes_round_engine #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .expanded_key(key10),
    .in_valid(in_valid10), .in_ready(in_ready10), .block_in(block_in), .out_valid(out_valid10),
    .out_ready(out_ready), .block_out(block_out10), .busy(busy10), .round_idx(round_idx10));
  aes_round_engine #(.NR(12)) u12 (.clk(clk), .rst_n(rst_n), .expanded_key(key12),
    .in_valid(in_valid12), .in_ready(in_ready12), .block_in(block_in), .out_valid(out_valid12),
    .out_ready(out_ready), .block_out(block_out12), .busy(busy12), .round_idx(round_idx12));
  aes_round_engine #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .expanded_key(key14),
    .in_valid(in_valid14), .in_ready(in_ready14), .block_in(block_in), .out_valid(out_valid14),
    .out_ready(out_ready), .block_out(block_out14), .busy(busy14), .round_idx(round_idx14));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Reference S-box from the GF(2^8) inverse and the affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key schedule, key MSB-aligned in 256 bits, result MSB-aligned in 1920 bits.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rcon;
    logic [1919:0] res;
    res = '0;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction

  // One NR=10 block with out_ready high, checking every cycle of the latency.
  task automatic run_block10(input logic [127:0] pt, input logic [127:0] exp, input string name);
    block_in = pt;
    in_valid10 = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if ({out_valid10, round_idx10} !== {1'b0, 4'(k+1)}) begin
        n_fail++;
        $display("FAIL %s step%0d: out_valid=%b round_idx=%0d, want 0/%0d", name, k, out_valid10, round_idx10, k+1);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if ({out_valid10, block_out10} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL %s result: out_valid=%b block_out=%h, want 1/%h", name, out_valid10, block_out10, exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid10, in_ready10, round_idx10} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b in_ready=%b round_idx=%0d, want 0/1/0", name, out_valid10, in_ready10, round_idx10);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({out_valid10, busy10, round_idx10, block_out10} !== {1'b0, 1'b0, 4'd0, 128'h0}) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b busy=%b round_idx=%0d block_out=%h, want 0/0/0/0", out_valid10, busy10, round_idx10, block_out10);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({in_ready10, in_ready12, in_ready14, busy12, busy14} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b%b%b busy12/14=%b%b, want 111/00", in_ready10, in_ready12, in_ready14, busy12, busy14);
    end
  endtask

  task automatic test_fips_b();
    sched = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    key10 = sched[1919 -: 1408];
    run_block10(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, "fips_b");
  endtask

  task automatic test_nr_variants();
    sched = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    key10 = sched[1919 -: 1408];
    sched = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    key12 = sched[1919 -: 1664];
    sched = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    key14 = sched;
    block_in = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b1;
    {in_valid10, in_valid12, in_valid14} = 3'b111;
    @(posedge clk); #1;
    {in_valid10, in_valid12, in_valid14} = 3'b000;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid10, out_valid12, out_valid14} !== {k == 10, k == 12, k == 14}) begin
        n_fail++;
        $display("FAIL nr_latency edge%0d: out_valid 10/12/14=%b%b%b", k, out_valid10, out_valid12, out_valid14);
      end
      if (k == 10) begin
        n_tests++;
        if (block_out10 !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
          n_fail++;
          $display("FAIL aes128_c1: block_out=%h want 69c4e0d86a7b0430d8cdb78070b4c55a", block_out10);
        end
      end
      if (k == 12) begin
        n_tests++;
        if (block_out12 !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
          n_fail++;
          $display("FAIL aes192_c2: block_out=%h want dda97ca4864cdfe06eaf70a0ec0d7191", block_out12);
        end
      end
      if (k == 14) begin
        n_tests++;
        if (block_out14 !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
          n_fail++;
          $display("FAIL aes256_c3: block_out=%h want 8ea2b7ca516745bfeafc49904b496089", block_out14);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_out_ready();
    for (int k = 0; k < 6; k++) begin
      out_ready = k[0];
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready10, busy10, out_valid10, round_idx10} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
        n_fail++;
        $display("FAIL idle_out_ready %0d: in_ready=%b busy=%b out_valid=%b round_idx=%0d, want 1/0/0/0", k, in_ready10, busy10, out_valid10, round_idx10);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] exp;
    int cnt;
    exp = 128'h3925841d02dc09fbdc118597196a0b32;
    sched = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    key10 = sched[1919 -: 1408];
    out_ready = 1'b0;
    block_in = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid10 = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    in_valid10 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_tests++;
      if ({out_valid10, in_ready10, round_idx10, block_out10} !== {1'b1, 1'b0, 4'd10, exp}) begin
        n_fail++;
        $display("FAIL back_pressure hold%0d: out_valid=%b in_ready=%b round_idx=%0d block_out=%h", k, out_valid10, in_ready10, round_idx10, block_out10);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid10, in_ready10, busy10} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b busy=%b, want 0/1/0", out_valid10, in_ready10, busy10);
    end
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    n_tests++;
    if ({busy10, round_idx10} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_next_accept: busy=%b round_idx=%0d, want 1/1", busy10, round_idx10);
    end
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20 && !out_valid10; k++) begin
      @(posedge clk); #1;
      cnt = k;
    end
    n_tests++;
    if ({out_valid10, block_out10} !== {1'b1, exp} || cnt != 10) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b block_out=%h after %0d cycles, want 1/%h after 10", out_valid10, block_out10, cnt, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] exps [4];
    logic [3:0] prev_ri;
    int nacc, nout, last_acc;
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734; exps[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    pts[1] = 128'h6bc1bee22e409f96e93d7e117393172a; exps[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pts[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; exps[2] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    pts[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; exps[3] = 128'h43b1cd7f598ece23881b00e3ed030688;
    nacc = 0; nout = 0; last_acc = 0; prev_ri = round_idx10;
    block_in = pts[0];
    in_valid10 = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 200 && nout < 4; cyc++) begin
      @(posedge clk); #1;
      if (round_idx10 == 4'd1 && prev_ri == 4'd0) begin
        if (nacc > 0) begin
          n_tests++;
          if (cyc - last_acc != 12) begin
            n_fail++;
            $display("FAIL b2b_spacing %0d: accepts %0d cycles apart, want 12", nacc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        nacc++;
        if (nacc < 4) block_in = pts[nacc];
        else in_valid10 = 1'b0;
      end
      if (out_valid10 && nout < 4) begin
        n_tests++;
        if (block_out10 !== exps[nout]) begin
          n_fail++;
          $display("FAIL b2b_out %0d: block_out=%h want %h", nout, block_out10, exps[nout]);
        end
        nout++;
      end
      prev_ri = round_idx10;
    end
    in_valid10 = 1'b0;
    n_tests++;
    if (nout != 4 || nacc != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d accepts %0d outputs, want 4/4", nacc, nout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    block_in = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid10 = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_tests++;
    if (round_idx10 !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_round_idx: round_idx=%0d want 5", round_idx10);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid10, busy10, round_idx10, block_out10, in_ready10} !== {1'b0, 1'b0, 4'd0, 128'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_round: out_valid=%b busy=%b round_idx=%0d block_out=%h", out_valid10, busy10, round_idx10, block_out10);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b1;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_tests++;
    if (out_valid10 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_done: out_valid=%b want 1", out_valid10);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid10, busy10, round_idx10, block_out10} !== {1'b0, 1'b0, 4'd0, 128'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_done: out_valid=%b busy=%b round_idx=%0d block_out=%h", out_valid10, busy10, round_idx10, block_out10);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_block10(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, "after_reset");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_nr_variants();
    test_idle_out_ready();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
